// File: rtl/trace_access_scheduler_pkg.sv
// Shared types and constants for the trace access scheduler.
package trace_access_scheduler_pkg;

  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned CORE_ID_W = 2;
  localparam int unsigned ADDR_W    = 32;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SETTLE = 2'd3
  } sched_state_t;

  // Access presented to the cache hierarchy; held from ISSUE until the next grant.
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [CORE_ID_W-1:0] core;
    logic                 wr;
  } access_t;

endpackage

// File: rtl/trace_access_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter4
  import trace_access_scheduler_pkg::*;
(
  input  logic [NUM_CORES-1:0] req,
  input  logic [CORE_ID_W-1:0] ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [CORE_ID_W-1:0] gnt_id,
  output logic                 any
);

  logic                 found;
  logic [CORE_ID_W-1:0] idx;

  // Rotating priority search; the 2-bit index wraps naturally mod 4.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = ptr + CORE_ID_W'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (found) gnt[gnt_id] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/trace_access_scheduler.sv
// Serialises four per-core trace sources onto the single-access cache hierarchy.
module trace_access_scheduler
  import trace_access_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned GAP_CYC     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES-1:0]        req_ins_type,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [CORE_ID_W-1:0]        core_id,
  output logic                        ins_type,
  output logic                        trace_ready,
  input  logic                        updated,
  output logic                        busy,
  output logic [NUM_CORES*CNT_W-1:0]  issue_count,
  output logic [CNT_W-1:0]            timeout_count
);

  // Timer is shared between the WAIT timeout and the SETTLE gap.
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] TMR_TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_GAP_LAST = TMR_W'(GAP_CYC - 1);

  sched_state_t         state_q;
  sched_state_t         state_d;
  logic [CORE_ID_W-1:0] rr_ptr_q;
  logic [TMR_W-1:0]     timer_q;
  access_t              acc_q;
  logic                 trace_ready_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     issue_cnt_q [NUM_CORES];
  logic [CNT_W-1:0]     timeout_cnt_q;

  logic [ADDR_W-1:0]    addr_a [NUM_CORES];
  logic [NUM_CORES-1:0] arb_gnt;
  logic [CORE_ID_W-1:0] arb_gnt_id;
  logic                 arb_any;

  logic                 grant_en;
  logic                 issue_en;
  logic                 timeout_en;
  logic                 timer_clr;
  logic                 timer_inc;

  // Per-core view of the flattened address bus.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  rr_arbiter4 u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_gnt_id),
    .any    (arb_any)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, handshake and datapath strobes.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    grant_en   = 1'b0;
    issue_en   = 1'b0;
    timeout_en = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any && reset) begin
          req_ready = arb_gnt;
          grant_en  = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_en  = 1'b1;
        timer_clr = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (updated) begin
          timer_clr = 1'b1;
          state_d   = ST_SETTLE;
        end else if (timer_q == TMR_TO_LAST) begin
          timeout_en = 1'b1;
          timer_clr  = 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_q == TMR_GAP_LAST) begin
          timer_clr = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // WAIT/SETTLE cycle timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         timer_q <= '0;
    else if (timer_clr) timer_q <= '0;
    else if (timer_inc) timer_q <= timer_q + TMR_W'(1);
  end

  // Capture the granted access and advance the round-robin pointer past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      rr_ptr_q <= '0;
    end else if (grant_en) begin
      acc_q    <= '{addr: addr_a[arb_gnt_id], core: arb_gnt_id, wr: req_ins_type[arb_gnt_id]};
      rr_ptr_q <= arb_gnt_id + CORE_ID_W'(1);
    end
  end

  // Start pulse is high exactly during ISSUE; busy tracks every non-IDLE state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      trace_ready_q <= (state_d == ST_ISSUE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  // Saturating per-core issue counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) issue_cnt_q[i] <= '0;
    end else if (issue_en && (issue_cnt_q[acc_q.core] != '1)) begin
      issue_cnt_q[acc_q.core] <= issue_cnt_q[acc_q.core] + CNT_W'(1);
    end
  end

  // Saturating timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                timeout_cnt_q <= '0;
    else if (timeout_en && (timeout_cnt_q != '1)) timeout_cnt_q <= timeout_cnt_q + CNT_W'(1);
  end

  assign mem_addr      = acc_q.addr;
  assign core_id       = acc_q.core;
  assign ins_type      = acc_q.wr;
  assign trace_ready   = trace_ready_q;
  assign busy          = busy_q;
  assign timeout_count = timeout_cnt_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt_out
    assign issue_count[g*CNT_W +: CNT_W] = issue_cnt_q[g];
  end

endmodule

// File: tb/tb_trace_access_scheduler.sv
// Randomised scoreboard bench for trace_access_scheduler.
module tb_trace_access_scheduler;

  localparam int NC  = 4;
  localparam int CW  = 20;
  localparam int SCW = 4;
  localparam int TO  = 64;
  localparam int GAP = 1;
  localparam int INF = 2147483647;

  typedef struct { logic [31:0] addr; logic wr; int d; bit stuck; } src_t;
  typedef struct { int cyc; int core; logic [31:0] addr; logic wr; } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [127:0]  req_addr;
  logic [3:0]    req_ins_type;
  logic          updated;

  logic [3:0]    req_ready,   s_req_ready;
  logic [31:0]   mem_addr,    s_mem_addr;
  logic [1:0]    core_id,     s_core_id;
  logic          ins_type,    s_ins_type;
  logic          trace_ready, s_trace_ready;
  logic          busy,        s_busy;
  logic [NC*CW-1:0]  issue_count;
  logic [NC*SCW-1:0] s_issue_count;
  logic [CW-1:0]     timeout_count;
  logic [SCW-1:0]    s_timeout_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Core request sources and reference-model state.
  src_t       src_q [NC][$];
  src_t       dly_q [$];
  txn_t       exp_q [$];
  logic [3:0] rdy_q [$];
  int m_rr, m_free, m_to;
  int m_cnt [NC];
  int upd_rise = INF;

  always #5 clk = ~clk;

  trace_access_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ins_type(req_ins_type), .req_ready(req_ready), .mem_addr(mem_addr),
    .core_id(core_id), .ins_type(ins_type), .trace_ready(trace_ready),
    .updated(updated), .busy(busy), .issue_count(issue_count),
    .timeout_count(timeout_count)
  );

  trace_access_scheduler #(.CNT_W(SCW)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ins_type(req_ins_type), .req_ready(s_req_ready), .mem_addr(s_mem_addr),
    .core_id(s_core_id), .ins_type(s_ins_type), .trace_ready(s_trace_ready),
    .updated(updated), .busy(s_busy), .issue_count(s_issue_count),
    .timeout_count(s_timeout_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NC; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic push(input int c, input logic [31:0] a, input logic wr, input int d, input bit st);
    src_t e;
    e.addr = a; e.wr = wr; e.d = d; e.stuck = st;
    src_q[c].push_back(e);
  endtask

  task automatic model_reset();
    m_rr = 0; m_free = 0; m_to = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    dly_q.delete();
    exp_q.delete();
  endtask

  // Sources, hierarchy responder and reference model, stepped once per cycle.
  logic [3:0] drv_seen;
  logic [3:0] exp_rdy;
  src_t       drv_e, drv_junk, rsp_e;
  txn_t       drv_t;
  int         drv_g, drv_p, drv_w, drv_j;
  bit         drv_found;

  initial begin : drv
    forever begin
      @(negedge clk);
      drv_seen = req_ready;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NC; i++)
        if (drv_seen[i] && src_q[i].size() > 0) drv_junk = src_q[i].pop_front();
      #1;
      for (int i = 0; i < NC; i++) begin
        req_valid[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          req_addr[32*i +: 32] = src_q[i][0].addr;
          req_ins_type[i]      = src_q[i][0].wr;
        end else begin
          req_addr[32*i +: 32] = '0;
          req_ins_type[i]      = 1'b0;
        end
      end
      // Hierarchy: completion level rises d cycles after the start pulse.
      if (reset !== 1'b1) begin
        upd_rise = INF;
        updated  = 1'b0;
      end else if (trace_ready === 1'b1) begin
        if (dly_q.size() > 0) rsp_e = dly_q.pop_front();
        else begin rsp_e.d = 1; rsp_e.stuck = 1'b0; end
        upd_rise = (rsp_e.d >= 1) ? cyc + rsp_e.d : INF;
        updated  = rsp_e.stuck;
      end else begin
        updated = (cyc >= upd_rise);
      end
      // Reference model: who is granted this cycle and when the scheduler is free again.
      exp_rdy = '0;
      if (reset === 1'b1 && cyc >= m_free) begin
        drv_found = 1'b0;
        drv_g = 0;
        for (int k = 0; k < NC; k++) begin
          drv_j = (m_rr + k) % NC;
          if (!drv_found && src_q[drv_j].size() > 0) begin
            drv_found = 1'b1;
            drv_g = drv_j;
          end
        end
        if (drv_found) begin
          drv_e = src_q[drv_g][0];
          exp_rdy[drv_g] = 1'b1;
          drv_p = cyc + 1;
          drv_t.cyc = drv_p; drv_t.core = drv_g; drv_t.addr = drv_e.addr; drv_t.wr = drv_e.wr;
          exp_q.push_back(drv_t);
          dly_q.push_back(drv_e);
          m_cnt[drv_g]++;
          m_rr = (drv_g + 1) % NC;
          if (drv_e.d >= 1 && drv_e.d <= TO) drv_w = drv_p + drv_e.d;
          else begin
            drv_w = drv_p + TO;
            m_to++;
          end
          m_free = drv_w + 1 + GAP;
        end
      end
      rdy_q.push_back(exp_rdy);
    end
  end

  // Monitor: compares handshakes every cycle and each issued access against the scoreboard.
  txn_t       mon_t;
  logic [3:0] mon_r;
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rdy_q.size() > 0) begin
        mon_r = rdy_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(mon_r));
        chk("sat_req_ready", 64'(s_req_ready), 64'(mon_r));
      end
      if (trace_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: trace_ready=1 core_id=%0d at cycle %0d, expected no issue", core_id, cyc);
        end else begin
          mon_t = exp_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(mon_t.cyc));
          chk("core_id", 64'(core_id), 64'(mon_t.core));
          chk("mem_addr", 64'(mem_addr), 64'(mon_t.addr));
          chk("ins_type", 64'(ins_type), 64'(mon_t.wr));
          chk("busy_in_issue", 64'(busy), 64'd1);
        end
      end
    end
  end

  task automatic quiesce(input string tag);
    int n;
    n = 0;
    while ((pending() != 0 || cyc < m_free + 2) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles, expected idle", tag, n);
    end
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_outstanding"}, 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("%s_issue_count%0d", tag, c), 64'(issue_count[c*CW +: CW]), 64'(sat(m_cnt[c], CW)));
      chk($sformatf("%s_sat_issue_count%0d", tag, c), 64'(s_issue_count[c*SCW +: SCW]), 64'(sat(m_cnt[c], SCW)));
    end
    chk({tag, "_timeout_count"}, 64'(timeout_count), 64'(sat(m_to, CW)));
    chk({tag, "_sat_timeout_count"}, 64'(s_timeout_count), 64'(sat(m_to, SCW)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_trace_ready"}, 64'(trace_ready), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_core_id"}, 64'(core_id), 64'd0);
    chk({tag, "_ins_type"}, 64'(ins_type), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_issue_count"}, 64'(issue_count), 64'd0);
    chk({tag, "_timeout_count"}, 64'(timeout_count), 64'd0);
    chk({tag, "_sat_issue_count"}, 64'(s_issue_count), 64'd0);
    chk({tag, "_sat_busy"}, 64'(s_busy), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset        = 1'b0;
    req_valid    = '0;
    req_addr     = '0;
    req_ins_type = '0;
    updated      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("init");
    reset = 1'b1;

    // All four cores continuously requesting: round-robin 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++)
        push(c, 32'h1000_0000 + 32'(16 * (r * NC + c)), 1'(c & 1), 2, 1'b0);
    quiesce("all4");

    // Single requester: core2 write, completion 3 cycles after the start pulse.
    push(2, 32'h0000_1A40, 1'b1, 3, 1'b0);
    quiesce("core2");

    // Same core re-granted each IDLE; drives the narrow counters into saturation.
    for (int n = 0; n < 20; n++) push(3, 32'h3000_0000 + 32'(n), 1'(n & 1), 1, 1'b0);
    quiesce("core3_sat");

    // Timeout with a request queued behind it, then completion exactly on the last WAIT cycle and one past it.
    push(0, 32'hDEAD_0000, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    push(1, 32'hBEEF_0004, 1'b1, 2, 1'b0);
    quiesce("timeout");
    push(2, 32'h0000_2222, 1'b0, TO, 1'b0);
    push(2, 32'h0000_3333, 1'b1, TO + 1, 1'b0);
    push(2, 32'h0000_4444, 1'b0, 1, 1'b0);
    quiesce("to_edge");

    // Completion level left high from the previous access through the next ISSUE.
    push(1, 32'hA000_0000, 1'b0, 2, 1'b0);
    push(1, 32'hA000_0004, 1'b1, 1, 1'b1);
    push(1, 32'hA000_0008, 1'b0, 2, 1'b0);
    quiesce("stuck");

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int c, r, d;
      bit st;
      c  = $urandom_range(0, 3);
      r  = $urandom_range(0, 99);
      st = 1'b0;
      if (r < 4)       d = 0;
      else if (r < 6)  d = TO;
      else if (r < 7)  d = TO + 1;
      else if (r < 12) begin d = 1; st = 1'b1; end
      else             d = $urandom_range(1, 6);
      push(c, $urandom(), 1'($urandom_range(0, 1)), d, st);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    quiesce("random");

    // Reset while core1 is waiting on the hierarchy; afterwards core0 wins over core3.
    push(1, 32'hCAFE_0040, 1'b1, 0, 1'b0);
    repeat (12) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_wait_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push(3, 32'h0000_0F03, 1'b0, 2, 1'b0);
    push(0, 32'h0000_0F00, 1'b1, 2, 1'b0);
    quiesce("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_access_scheduler.md
Name: trace_access_scheduler

Overview:
- Shares the single-access cache-hierarchy datapath (4x L1, L2, subset L2s, prefetcher, MESI bus) between four per-core trace sources.
- Round-robin arbitrates among pending core requests and drives mem_addr/core_id/ins_type/trace_ready one access at a time.
- Waits for the hierarchy's updated completion (or a timeout) plus a settle gap before issuing the next access.
- Keeps per-core issue counters and a timeout counter.

Parameters:
- CNT_W, 20, width of every statistics counter
- TIMEOUT_CYC, 64, max WAIT cycles before an access is force-retired (>=2)
- GAP_CYC, 1, SETTLE cycles between completion and next grant (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  4  bit i: core i has a trace entry pending
- req_addr  in  128  core i address at [32i+31:32i]
- req_ins_type  in  4  bit i: core i access type (1 = write, 0 = read)
- req_ready  out  4  bit i: core i entry accepted this cycle (one-hot or zero)
- mem_addr  out  32  address to hierarchy, registered
- core_id  out  2  requesting core to hierarchy, registered
- ins_type  out  1  access type to hierarchy, registered
- trace_ready  out  1  one-cycle start pulse to hierarchy
- updated  in  1  hierarchy completion level
- busy  out  1  high in any state except IDLE
- issue_count  out  4*CNT_W  core i accesses issued at [CNT_W*i+CNT_W-1:CNT_W*i]
- timeout_count  out  CNT_W  accesses retired by timeout

Behaviour:
- Reset (reset=0, async): FSM=IDLE, rr_ptr=0, timer=0, mem_addr=0, core_id=0, ins_type=0, trace_ready=0, busy=0, all counters=0, req_ready=0. In-flight access is dropped, not counted as timeout.
- FSM states: IDLE, ISSUE, WAIT, SETTLE.
- IDLE:
  - req_ready is combinational. Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod 4.
  - req_ready[g]=1 only when any req_valid is high; handshake completes that cycle.
  - On grant, register mem_addr=req_addr[g], core_id=g, ins_type=req_ins_type[g], rr_ptr=(g+1) mod 4; go to ISSUE.
  - No valid: stay in IDLE, outputs hold their previous values.
- ISSUE (exactly 1 cycle):
  - trace_ready=1; issue_count[core_id] += 1, saturating at all-ones; timer=0; go to WAIT.
  - updated is ignored in this cycle.
- WAIT:
  - timer += 1 each cycle.
  - updated=1: go to SETTLE.
  - Else if timer==TIMEOUT_CYC-1: timeout_count += 1 (saturating), go to SETTLE.
  - updated=1 in the timeout cycle counts as completion, not timeout.
- SETTLE:
  - Lasts GAP_CYC cycles (counter reused), trace_ready=0, then go to IDLE.
- Output hold: mem_addr/core_id/ins_type are stable from ISSUE until the next grant. Downstream caches decode them combinationally.
- req_ready=0 in all states except IDLE. A core's req_valid/req_addr must hold until accepted.
- Latency: grant cycle T; trace_ready at T+1; first updated sample at T+2. Best-case spacing between trace_ready pulses = 3+GAP_CYC cycles.
- Fairness: a continuously requesting core waits at most 3 other grants.
- Single-requester case: the same core is re-granted each IDLE.

Decomposition:
- Shared package:
  - NUM_CORES=4, CORE_ID_W=2, ADDR_W=32
  - FSM state typedef/encoding (IDLE=0, ISSUE=1, WAIT=2, SETTLE=3)
- Sub-module rr_arbiter4: combinational, inputs req[3:0] and ptr[1:0], outputs gnt one-hot, gnt_id[1:0], any.
- FSM, timer and counters live in the top.

Test Plan:
- Only core2 valid, addr 0x0000_1A40, write; updated asserted 3 cycles after trace_ready.
  - req_ready=4'b0100 in the grant cycle; trace_ready 1 cycle later; mem_addr=0x0000_1A40, core_id=2, ins_type=1.
  - issue_count core2=1; IDLE after GAP_CYC.
- All four valid continuously, updated returned 2 cycles after each trace_ready.
  - Grant order 0,1,2,3,0,...; each issue_count=2 after 8 accesses; timeout_count=0.
- updated held 0, TIMEOUT_CYC=64.
  - Exactly 64 WAIT cycles, then timeout_count=1, then SETTLE, then IDLE; a queued request is granted next.
- updated stuck high from the previous access during ISSUE.
  - Ignored in ISSUE; completion taken in the first WAIT cycle (T+2); no double issue.
- reset pulled low mid-WAIT (core1 in flight).
  - Immediately busy=0, trace_ready=0, mem_addr=0, counters=0; after release core0 has priority (rr_ptr=0).
- Counters near saturation: CNT_W=4 override, core3 issues 20 accesses.
  - issue_count core3 sticks at 15.
